// File: rtl/result_trace_buffer_if.sv
// ----------------------------------------------------------------------------
// result_trace_buffer_if
//   Drain-side handshake of the result trace buffer. It carries the head entry
//   of the FIFO towards a host/log sink.
//   out_data  : head entry (don't-care while out_valid is low)
//   out_valid : buffer holds at least one entry
//   out_ready : sink accepts the head entry this cycle
//   master modport : used by the buffer
//   slave modport  : used by the sink
// ----------------------------------------------------------------------------
interface result_trace_buffer_if #(
   parameter int OUT_W = 32
);
   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/result_trace_buffer.sv
// ----------------------------------------------------------------------------
// result_trace_buffer
//   Watches the core's result bus and pushes every new value (a value that
//   differs from the last captured one, or the very first one after reset)
//   into a first-word-fall-through FIFO. The FIFO is drained over a
//   valid/ready port. If a capture arrives while the FIFO is full and nothing
//   is leaving, the entry is dropped and a sticky overflow flag is raised.
//
//   Optional build macro RESULT_TRACE_TIMESTAMP_EN: adds a free-running
//   TS_W-bit cycle counter. Each entry then becomes {timestamp, result}.
//
// Ports
//   clock    : single clock, rising edge
//   rst      : asynchronous reset, active low
//   cap_en   : capture enable
//   result   : core result bus, sampled on the rising edge
//   out_if   : drain handshake (out_data / out_valid / out_ready)
//   count    : current FIFO occupancy
//   overflow : sticky flag, a capture was dropped because the FIFO was full
//   clr_ovf  : synchronous clear of overflow
// ----------------------------------------------------------------------------
module result_trace_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int TS_W   = 16
) (
   input  logic                     clock,
   input  logic                     rst,
   input  logic                     cap_en,
   input  logic [DATA_W-1:0]        result,
   result_trace_buffer_if.master    out_if,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   input  logic                     clr_ovf
);

`ifdef RESULT_TRACE_TIMESTAMP_EN
   localparam bit TS_EN = 1'b1;
`else
   localparam bit TS_EN = 1'b0;
`endif
   localparam int OUT_W = TS_EN ? (TS_W + DATA_W) : DATA_W;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [OUT_W-1:0]  mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic [CNT_W-1:0]  count_nxt_s;
   logic              valid_r;
   logic              overflow_r;
   logic              overflow_nxt_s;
   logic              first_r;
   logic [DATA_W-1:0] last_r;
   logic [OUT_W-1:0]  entry_s;
   logic              full_s;
   logic              push_s;
   logic              pop_s;
   logic              wr_s;
   logic              drop_s;

`ifdef RESULT_TRACE_TIMESTAMP_EN
   logic [TS_W-1:0]   ts_cnt_r;

   // Free-running cycle counter; the value present at the capturing edge is stored.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         ts_cnt_r <= {TS_W{1'b0}};
      end else begin
         ts_cnt_r <= ts_cnt_r + TS_W'(1);
      end
   end

   assign entry_s = {ts_cnt_r, result};
`else
   assign entry_s = result;
`endif

   assign full_s = (count_r == CNT_W'(DEPTH));
   // The first capture after reset is unconditional, later ones only on change.
   assign push_s = cap_en & (first_r | (result != last_r));
   assign pop_s  = valid_r & out_if.out_ready;
   // A pop frees the slot at the same edge, so a full FIFO can still accept.
   assign wr_s   = push_s & (~full_s | pop_s);
   assign drop_s = push_s & full_s & ~pop_s;

   // Occupancy next-state: moves only when exactly one of write/pop happens.
   always_comb begin
      count_nxt_s = count_r;
      if (wr_s && !pop_s) begin
         count_nxt_s = count_r + CNT_W'(1);
      end else if (pop_s && !wr_s) begin
         count_nxt_s = count_r - CNT_W'(1);
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Overflow next-state: a drop in the same cycle beats a clear request.
   always_comb begin
      overflow_nxt_s = overflow_r;
      if (drop_s) begin
         overflow_nxt_s = 1'b1;
      end else if (clr_ovf) begin
         overflow_nxt_s = 1'b0;
      end else begin
         overflow_nxt_s = overflow_r;
      end
   end

   // Control state: pointers, occupancy, valid, overflow and change detector.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         count_r    <= {CNT_W{1'b0}};
         valid_r    <= 1'b0;
         overflow_r <= 1'b0;
         first_r    <= 1'b1;
         last_r     <= {DATA_W{1'b0}};
      end else begin
         if (wr_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         // last/first track every push, including dropped ones.
         if (push_s) begin
            last_r  <= result;
            first_r <= 1'b0;
         end
         count_r    <= count_nxt_s;
         valid_r    <= (count_nxt_s != {CNT_W{1'b0}});
         overflow_r <= overflow_nxt_s;
      end
   end

   // Storage array; deliberately not reset, contents are masked by valid.
   always_ff @(posedge clock) begin
      if (wr_s) begin
         mem_r[wr_ptr_r] <= entry_s;
      end
   end

   assign out_if.out_data  = mem_r[rd_ptr_r];
   assign out_if.out_valid = valid_r;
   assign count            = count_r;
   assign overflow         = overflow_r;

endmodule

// File: tb/tb_result_trace_buffer.sv
`timescale 1ns/1ps
module tb_result_trace_buffer;

`ifdef RESULT_TRACE_TIMESTAMP_EN
   localparam int OUT_W = 48;
`else
   localparam int OUT_W = 32;
`endif

   typedef struct packed {
      logic [31:0] data;
      logic [15:0] ts;
      logic        has_ts;
   } exp_t;

   logic        clock;
   logic        rst;
   logic        cap_en;
   logic [31:0] result;
   logic [4:0]  count;
   logic        overflow;
   logic        clr_ovf;

   int checks = 0;
   int errors = 0;
   exp_t exp_q [$];

   result_trace_buffer_if #(.OUT_W(OUT_W)) bus ();

   result_trace_buffer dut (
      .clock    (clock),
      .rst      (rst),
      .cap_en   (cap_en),
      .result   (result),
      .out_if   (bus),
      .count    (count),
      .overflow (overflow),
      .clr_ovf  (clr_ovf)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #5ms;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic exp_push(input logic [31:0] v);
      exp_t e;
      e.data   = v;
      e.ts     = 16'h0000;
      e.has_ts = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic drive_val(input logic [31:0] v);
      result = v;
      step();
   endtask

   task automatic drain_all(input string name);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (count == 5'd0) break;
         step();
      end
      bus.out_ready = 1'b0;
      chk({name, "_drained"}, 64'(count), 64'd0);
      chk({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
   endtask

   // Scoreboard monitor: compares each accepted head entry with the queue.
   always @(negedge clock) begin
      exp_t e;
      logic ok;
      if (rst && bus.out_valid && bus.out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow actual=%0h required=none", bus.out_data);
         end else begin
            e  = exp_q.pop_front();
            ok = (bus.out_data[31:0] === e.data);
`ifdef RESULT_TRACE_TIMESTAMP_EN
            if (e.has_ts && (bus.out_data[47:32] !== e.ts)) ok = 1'b0;
`endif
            if (!ok) begin
               errors++;
               $display("FAIL sb_data actual=%0h required=%0h/%0h", bus.out_data, e.ts, e.data);
            end
         end
      end
   end

   initial begin
      rst           = 1'b1;
      cap_en        = 1'b1;
      result        = 32'hA5;
      clr_ovf       = 1'b0;
      bus.out_ready = 1'b0;
      #1 rst = 1'b0;

      // T1 reset
      step(); step();
      chk("t1_valid_rst", 64'(bus.out_valid), 64'd0);
      chk("t1_count_rst", 64'(count), 64'd0);
      chk("t1_ovf_rst", 64'(overflow), 64'd0);
      rst = 1'b1;
      exp_push(32'hA5);
      step();
      chk("t1_count_cap", 64'(count), 64'd1);
      chk("t1_valid_cap", 64'(bus.out_valid), 64'd1);
      drain_all("t1");

      // T2 dedupe
      drive_val(32'd5); drive_val(32'd5); drive_val(32'd5); drive_val(32'd7);
      exp_push(32'd5); exp_push(32'd7);
      chk("t2_count", 64'(count), 64'd2);
      chk("t2_head", 64'(bus.out_data[31:0]), 64'd5);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk("t2_head_after_pop", 64'(bus.out_data[31:0]), 64'd7);
      chk("t2_count_after_pop", 64'(count), 64'd1);
      drain_all("t2");

      // T3 overflow, clear racing a drop, then explicit clear
      for (int i = 1; i <= 17; i++) begin
         drive_val(32'(i));
         if (i <= 16) exp_push(32'(i));
      end
      chk("t3_count_full", 64'(count), 64'd16);
      chk("t3_ovf_set", 64'(overflow), 64'd1);
      result  = 32'd18;
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      chk("t3_drop_beats_clr", 64'(overflow), 64'd1);
      chk("t3_count_after_drop", 64'(count), 64'd16);
      drain_all("t3");
      chk("t3_ovf_sticky", 64'(overflow), 64'd1);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      chk("t3_ovf_clr", 64'(overflow), 64'd0);

      // T4 full with simultaneous push and pop
      for (int i = 1; i <= 16; i++) begin
         drive_val(32'(i));
         exp_push(32'(i));
      end
      chk("t4_count_full", 64'(count), 64'd16);
      bus.out_ready = 1'b1;
      result = 32'd99;
      exp_push(32'd99);
      step();
      chk("t4_count_stays", 64'(count), 64'd16);
      chk("t4_no_ovf", 64'(overflow), 64'd0);
      drain_all("t4");

      // cap_en low holds the change detector
      cap_en = 1'b0;
      drive_val(32'd55);
      step();
      chk("capen_off_count", 64'(count), 64'd0);
      cap_en = 1'b1;
      exp_push(32'd55);
      step();
      chk("capen_on_count", 64'(count), 64'd1);
      drain_all("capen");

      // T5 reset mid-stream
      drive_val(32'd10); drive_val(32'd11); drive_val(32'd12);
      chk("t5_count3", 64'(count), 64'd3);
      #2 rst = 1'b0;
      #1;
      chk("t5_valid_async", 64'(bus.out_valid), 64'd0);
      chk("t5_count_async", 64'(count), 64'd0);
      exp_q.delete();
      step();
      rst = 1'b1;
      exp_push(32'd12);
      step();
      chk("t5_recapture", 64'(count), 64'd1);
      drain_all("t5");

`ifdef RESULT_TRACE_TIMESTAMP_EN
      // T6 timestamps at cycles 2 and 5 after release, then counter wrap
      begin
         exp_t e;
         cap_en = 1'b0;
         rst    = 1'b0;
         step();
         rst = 1'b1;
         step(); step();
         cap_en = 1'b1; result = 32'd3;
         e.data = 32'd3; e.ts = 16'd2; e.has_ts = 1'b1; exp_q.push_back(e);
         step();
         cap_en = 1'b0;
         step(); step();
         cap_en = 1'b1; result = 32'd4;
         e.data = 32'd4; e.ts = 16'd5; e.has_ts = 1'b1; exp_q.push_back(e);
         step();
         cap_en = 1'b0;
         chk("t6_count", 64'(count), 64'd2);
         drain_all("t6");

         rst = 1'b0;
         step();
         rst = 1'b1;
         for (int i = 0; i < 65535; i++) step();
         cap_en = 1'b1; result = 32'd7;
         e.data = 32'd7; e.ts = 16'hFFFF; e.has_ts = 1'b1; exp_q.push_back(e);
         step();
         result = 32'd8;
         e.data = 32'd8; e.ts = 16'h0000; e.has_ts = 1'b1; exp_q.push_back(e);
         step();
         cap_en = 1'b0;
         chk("t6_wrap_count", 64'(count), 64'd2);
         drain_all("t6_wrap");
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
